// File: rtl/reg_file_dbg_if.sv
// Bundle of the register-file access ports and the dump stream handshake.
// The slave modport faces the register file and the master modport faces whoever drives it.
interface reg_file_dbg_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic                  i_regwrite;
  logic [ADDR_WIDTH-1:0] i_wraddr;
  logic [DATA_WIDTH-1:0] i_writedata;
  logic [ADDR_WIDTH-1:0] i_rs;
  logic [ADDR_WIDTH-1:0] i_rt;
  logic [DATA_WIDTH-1:0] o_regA;
  logic [DATA_WIDTH-1:0] o_regB;

  logic                  i_dump_start;
  logic                  i_dump_ready;
  logic                  o_dump_valid;
  logic [ADDR_WIDTH-1:0] o_dump_addr;
  logic [DATA_WIDTH-1:0] o_dump_data;
  logic                  o_dump_busy;
  logic                  o_dump_done;

  modport slave (
    input  i_regwrite, i_wraddr, i_writedata, i_rs, i_rt,
    input  i_dump_start, i_dump_ready,
    output o_regA, o_regB,
    output o_dump_valid, o_dump_addr, o_dump_data, o_dump_busy, o_dump_done
  );

  modport master (
    output i_regwrite, i_wraddr, i_writedata, i_rs, i_rt,
    output i_dump_start, i_dump_ready,
    input  o_regA, o_regB,
    input  o_dump_valid, o_dump_addr, o_dump_data, o_dump_busy, o_dump_done
  );

endinterface

// File: rtl/reg_file_dbg.sv
// Register file with two combinational read ports and one write port.
// Also has a debug dump engine that streams every register out over a valid/ready handshake.
// Register 0 can be hardwired to zero.
// Same-cycle write-to-read forwarding on the read ports is optional.
module reg_file_dbg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic           i_clock,
  input  logic           i_reset,
  reg_file_dbg_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DEPTH - 1);
  localparam bit ZeroRegEn = (ZERO_REG != 0);
  localparam bit BypassEn  = (BYPASS != 0);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } dumpState_t;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  writeEn;

  dumpState_t            dumpState_q;
  dumpState_t            dumpState_d;
  logic [ADDR_WIDTH-1:0] dumpPtr_q;
  logic [ADDR_WIDTH-1:0] dumpPtr_d;

  // A write is dropped in two cases: it targets the hardwired zero register, or reset is active.
  // The forwarding path uses this same qualified enable, so it never shows data that will not be stored.
  always_comb begin
    writeEn = bus.i_regwrite && !i_reset;
    if (ZeroRegEn && (bus.i_wraddr == '0)) begin
      writeEn = 1'b0;
    end
  end

  // Storage array: cleared asynchronously on reset, otherwise written on the rising edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (writeEn) begin
      regs_q[bus.i_wraddr] <= bus.i_writedata;
    end
  end

  // Read port A: stored value, then optional forwarding of an in-flight write, then the zero-register mask.
  always_comb begin
    bus.o_regA = regs_q[bus.i_rs];
    if (BypassEn && writeEn && (bus.i_wraddr == bus.i_rs)) begin
      bus.o_regA = bus.i_writedata;
    end
    if (ZeroRegEn && (bus.i_rs == '0)) begin
      bus.o_regA = '0;
    end
  end

  // Read port B: resolved exactly like port A but on its own index, so equal indices give equal data.
  always_comb begin
    bus.o_regB = regs_q[bus.i_rt];
    if (BypassEn && writeEn && (bus.i_wraddr == bus.i_rt)) begin
      bus.o_regB = bus.i_writedata;
    end
    if (ZeroRegEn && (bus.i_rt == '0)) begin
      bus.o_regB = '0;
    end
  end

  // Dump engine state and beat pointer; reset aborts any dump in progress without a done pulse.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      dumpState_q <= IDLE;
      dumpPtr_q   <= '0;
    end else begin
      dumpState_q <= dumpState_d;
      dumpPtr_q   <= dumpPtr_d;
    end
  end

  // Dump next-state and outputs.
  // A dump beat carries the stored value only, with no forwarding.
  // A write landing on the current index therefore shows up after its edge.
  always_comb begin
    dumpState_d      = dumpState_q;
    dumpPtr_d        = dumpPtr_q;
    bus.o_dump_valid = 1'b0;
    bus.o_dump_addr  = '0;
    bus.o_dump_data  = '0;
    bus.o_dump_busy  = 1'b0;
    bus.o_dump_done  = 1'b0;

    case (dumpState_q)
      IDLE: begin
        if (bus.i_dump_start) begin
          dumpState_d = SEND;
          dumpPtr_d   = '0;
        end
      end

      SEND: begin
        bus.o_dump_valid = 1'b1;
        bus.o_dump_busy  = 1'b1;
        bus.o_dump_addr  = dumpPtr_q;
        bus.o_dump_data  = regs_q[dumpPtr_q];
        if (ZeroRegEn && (dumpPtr_q == '0)) begin
          bus.o_dump_data = '0;
        end
        if (bus.i_dump_ready) begin
          if (dumpPtr_q == LastIdx) begin
            dumpState_d = DONE;
            dumpPtr_d   = '0;
          end else begin
            dumpPtr_d = dumpPtr_q + ADDR_WIDTH'(1);
          end
        end
      end

      DONE: begin
        bus.o_dump_busy = 1'b1;
        bus.o_dump_done = 1'b1;
        dumpState_d     = IDLE;
      end

      default: begin
        dumpState_d = IDLE;
        dumpPtr_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_file_dbg.sv
// Directed testbench for reg_file_dbg.
// It covers reads, writes, the zero register and forwarding.
// A second instance built without forwarding is used to compare against old-value reads.
// It also exercises the dump engine: full speed, throttled with a concurrent write, and aborted by reset.
module tb_reg_file_dbg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2 ** AW;

  logic clock;
  logic reset;

  int checkCount;
  int passCount;
  int failCount;

  logic [DW-1:0] model [DEPTH];
  int            expPtr;
  int            cyc;
  bit            wrote;

  reg_file_dbg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  reg_file_dbg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busNoByp ();

  reg_file_dbg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .i_clock (clock),
    .i_reset (reset),
    .bus     (bus.slave)
  );

  reg_file_dbg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(0)) dutNoByp (
    .i_clock (clock),
    .i_reset (reset),
    .bus     (busNoByp.slave)
  );

  // Free-running 10 ns clock with rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive the register access fields of both instances identically so their contents stay in step.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    bus.i_regwrite       = we;
    bus.i_wraddr         = wa;
    bus.i_writedata      = wd;
    bus.i_rs             = rs;
    bus.i_rt             = rt;
    busNoByp.i_regwrite  = we;
    busNoByp.i_wraddr    = wa;
    busNoByp.i_writedata = wd;
    busNoByp.i_rs        = rs;
    busNoByp.i_rt        = rt;
  endtask

  // One comparison: count it, and report tag/observed/expected when it does not hold.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge so new inputs never race the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;

    reset = 1'b1;
    applyStimulus(1'b0, '0, '0, '0, '0);
    bus.i_dump_start      = 1'b0;
    bus.i_dump_ready      = 1'b0;
    busNoByp.i_dump_start = 1'b0;
    busNoByp.i_dump_ready = 1'b0;

    // Reset state.
    #12;
    checkOutput("rst_valid", DW'(bus.o_dump_valid), 32'h0);
    checkOutput("rst_busy",  DW'(bus.o_dump_busy),  32'h0);
    checkOutput("rst_done",  DW'(bus.o_dump_done),  32'h0);
    checkOutput("rst_addr",  DW'(bus.o_dump_addr),  32'h0);
    checkOutput("rst_data",  bus.o_dump_data,       32'h0);
    checkOutput("rst_regA",  bus.o_regA,            32'h0);

    tick();
    reset = 1'b0;

    // Write r5, then read it on both ports the next cycle.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #1;
    checkOutput("r5_regA", bus.o_regA, 32'hDEADBEEF);
    checkOutput("r5_regB", bus.o_regB, 32'hDEADBEEF);

    // Write to r0 is discarded, with no forwarding, both before and after the edge.
    applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5);
    #1;
    checkOutput("r0_same_cycle", bus.o_regA, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    checkOutput("r0_after_edge", bus.o_regA, 32'h0);

    // Forwarding: the bypass instance sees the new data, the other sees the old zero.
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5);
    #1;
    checkOutput("byp_regA",      bus.o_regA,      32'hA5A5A5A5);
    checkOutput("byp_regB_indep", bus.o_regB,     32'hDEADBEEF);
    checkOutput("nobyp_regA",    busNoByp.o_regA, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    #1;
    checkOutput("nobyp_stored",  busNoByp.o_regA, 32'hA5A5A5A5);
    checkOutput("byp_stored_B",  bus.o_regB,      32'hA5A5A5A5);

    // Load r[i] = i + 100 (the r0 write is dropped).
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, AW'(i), DW'(i + 100), 5'd0, 5'd0);
      model[i] = (i == 0) ? 32'h0 : DW'(i + 100);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Full-speed dump.
    bus.i_dump_start = 1'b1;
    bus.i_dump_ready = 1'b1;
    tick();
    bus.i_dump_start = 1'b0;
    for (int b = 0; b < DEPTH; b++) begin
      #1;
      checkOutput($sformatf("fast_valid_%0d", b), DW'(bus.o_dump_valid), 32'h1);
      checkOutput($sformatf("fast_addr_%0d", b),  DW'(bus.o_dump_addr),  DW'(b));
      checkOutput($sformatf("fast_data_%0d", b),  bus.o_dump_data,       model[b]);
      tick();
    end
    #1;
    checkOutput("fast_done_pulse", DW'(bus.o_dump_done),  32'h1);
    checkOutput("fast_done_valid", DW'(bus.o_dump_valid), 32'h0);
    checkOutput("fast_done_busy",  DW'(bus.o_dump_busy),  32'h1);
    bus.i_dump_start = 1'b1;
    tick();
    bus.i_dump_start = 1'b0;
    #1;
    checkOutput("done_one_cycle",  DW'(bus.o_dump_done), 32'h0);
    checkOutput("start_in_done_ignored", DW'(bus.o_dump_busy), 32'h0);

    // Throttled dump, with r3 rewritten while the pointer sits at 2.
    bus.i_dump_start = 1'b1;
    tick();
    bus.i_dump_start = 1'b0;
    expPtr = 0;
    cyc    = 0;
    wrote  = 1'b0;
    while ((expPtr < DEPTH) && (cyc < 400)) begin
      bus.i_dump_ready = cyc[0];
      if ((expPtr == 2) && !wrote) begin
        applyStimulus(1'b1, 5'd3, 32'h55, 5'd0, 5'd0);
      end else begin
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      end
      #1;
      if (bus.o_dump_valid !== 1'b1 || bus.o_dump_addr !== AW'(expPtr) || bus.o_dump_data !== model[expPtr]) begin
        checkOutput($sformatf("slow_addr_%0d", expPtr), DW'(bus.o_dump_addr), DW'(expPtr));
        checkOutput($sformatf("slow_data_%0d", expPtr), bus.o_dump_data,      model[expPtr]);
        checkOutput($sformatf("slow_valid_%0d", expPtr), DW'(bus.o_dump_valid), 32'h1);
      end else if (expPtr == 3) begin
        checkOutput("slow_beat3_data", bus.o_dump_data, 32'h55);
      end
      tick();
      if (bus.i_regwrite) begin
        model[3] = 32'h55;
        wrote    = 1'b1;
      end
      if (cyc[0]) begin
        expPtr++;
      end
      cyc++;
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    bus.i_dump_ready = 1'b1;
    checkOutput("slow_all_beats_in_budget", DW'(expPtr), DW'(DEPTH));
    #1;
    checkOutput("slow_done_pulse", DW'(bus.o_dump_done), 32'h1);
    tick();

    // Reset in the middle of a dump.
    bus.i_dump_start = 1'b1;
    tick();
    bus.i_dump_start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      tick();
    end
    #1;
    checkOutput("mid_addr_10", DW'(bus.o_dump_addr), 32'd10);
    reset = 1'b1;
    applyStimulus(1'b1, 5'd5, 32'h1, 5'd5, 5'd31);
    #1;
    checkOutput("abort_valid", DW'(bus.o_dump_valid), 32'h0);
    checkOutput("abort_busy",  DW'(bus.o_dump_busy),  32'h0);
    checkOutput("abort_done",  DW'(bus.o_dump_done),  32'h0);
    checkOutput("abort_regA",  bus.o_regA,            32'h0);
    checkOutput("abort_regB",  bus.o_regB,            32'h0);
    tick();
    checkOutput("write_in_reset_ignored", bus.o_regA, 32'h0);
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    tick();
    checkOutput("no_done_after_abort", DW'(bus.o_dump_done), 32'h0);
    checkOutput("cleared_r5", bus.o_regA, 32'h0);
    bus.i_dump_start = 1'b1;
    tick();
    bus.i_dump_start = 1'b0;
    #1;
    checkOutput("restart_valid", DW'(bus.o_dump_valid), 32'h1);
    checkOutput("restart_addr",  DW'(bus.o_dump_addr),  32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reg_file_dbg.md
REG_FILE_DBG -- requirements
Module: reg_file_dbg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register and data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 SHALL have parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1, 1 = write-to-read forwarding within the same cycle.
REQ-005 SHALL provide a single clock and an asynchronous, active-high reset.
REQ-006 i_clock  in  1  sole clock, rising edge.
REQ-007 i_reset  in  1  asynchronous, active-high reset.
REQ-008 i_regwrite  in  1  write enable.
REQ-009 i_wraddr  in  ADDR_WIDTH  write index.
REQ-010 i_writedata  in  DATA_WIDTH  write data.
REQ-011 i_rs  in  ADDR_WIDTH  read port A index.
REQ-012 i_rt  in  ADDR_WIDTH  read port B index.
REQ-013 o_regA  out  DATA_WIDTH  read port A data.
REQ-014 o_regB  out  DATA_WIDTH  read port B data.
REQ-015 i_dump_start  in  1  request a full register dump.
REQ-016 i_dump_ready  in  1  dump consumer ready.
REQ-017 o_dump_valid  out  1  dump beat valid.
REQ-018 o_dump_addr  out  ADDR_WIDTH  index of current dump beat.
REQ-019 o_dump_data  out  DATA_WIDTH  content of current dump beat.
REQ-020 o_dump_busy  out  1  dump in progress (SEND or DONE).
REQ-021 o_dump_done  out  1  one-cycle pulse after last beat accepted.

Function
REQ-022 Write SHALL occur on the rising edge when i_regwrite=1, except ZERO_REG=1 and i_wraddr=0 (write discarded).
REQ-023 Read ports SHALL be combinational: o_regA = reg[i_rs], o_regB = reg[i_rt], zero-cycle latency.
REQ-024 With ZERO_REG=1, any read or dump of index 0 SHALL return 0.
REQ-025 With BYPASS=1, a read whose index equals i_wraddr while i_regwrite=1 SHALL return i_writedata, unless the write is discarded per REQ-022; with BYPASS=0 it SHALL return the stored (old) value.
REQ-026 Both read ports SHALL resolve independently; i_rs = i_rt SHALL return identical data.
REQ-027 Dump FSM SHALL have states IDLE, SEND, DONE.
REQ-028 IDLE: i_dump_start=1 SHALL transition to SEND with dump pointer = 0; otherwise stay.
REQ-029 SEND: o_dump_valid=1, o_dump_addr = pointer, o_dump_data = stored reg[pointer] (no bypass).
REQ-030 SEND: a beat is accepted when o_dump_valid=1 and i_dump_ready=1 at a rising edge; pointer = DEPTH-1 SHALL go to DONE, else pointer increments by 1.
REQ-031 SEND with i_dump_ready=0 SHALL hold pointer and o_dump_addr; o_dump_data SHALL track stored contents of that index.
REQ-032 DONE: o_dump_done=1 for exactly one cycle, then IDLE; o_dump_valid=0 in DONE.
REQ-033 i_dump_start outside IDLE SHALL be ignored; start in the same cycle DONE exits SHALL NOT be registered.
REQ-034 Register writes SHALL remain fully functional during a dump; a beat reports the stored value at its acceptance edge.
REQ-035 A dump SHALL emit exactly DEPTH beats, indices 0..DEPTH-1 in order, no wrap or repeat.

Reset
REQ-036 i_reset=1 SHALL asynchronously clear all DEPTH registers to 0.
REQ-037 i_reset=1 SHALL force FSM to IDLE, pointer 0, o_dump_valid=0, o_dump_busy=0, o_dump_done=0, o_dump_addr=0, o_dump_data=0.
REQ-038 After reset, o_regA/o_regB SHALL read 0 for every index; writes while i_reset=1 SHALL be ignored.
REQ-039 Reset asserted mid-dump SHALL abort it with no o_dump_done pulse.

Verification
REQ-040 Write 0xDEADBEEF to r5, next cycle i_rs=5, i_rt=5 -> o_regA=o_regB=0xDEADBEEF.
REQ-041 ZERO_REG=1: write 0x12345678 to r0 with i_rs=0 -> o_regA=0 same cycle and after edge.
REQ-042 BYPASS=1: i_regwrite=1, i_wraddr=7, i_writedata=0xA5A5A5A5, i_rs=7 -> o_regA=0xA5A5A5A5 before the edge; BYPASS=0 -> old value 0.
REQ-043 Load r[i]=i+100, pulse i_dump_start, i_dump_ready=1 -> 32 beats addr 0..31, data 0,101..131, o_dump_done one cycle after beat 31.
REQ-044 Dump with i_dump_ready toggling 0/1 each cycle and a write to r3=0x55 while pointer=2 -> beat 3 data=0x55, no beat lost or duplicated.
REQ-045 Assert i_reset at beat 10 of a dump -> valid, busy, done 0 immediately; all reads 0; new i_dump_start restarts at addr 0.
